ysyx_icache: RTL and testbench

Direct-mapped, read-only instruction cache between the IFU and the bus arbiter's ifu read port (ifu_araddr / ifu_arvalid / ifu_rdata_o / ifu_rvalid_o).
- Hits return in one cycle.
- Misses refill a whole line with single-word reads through the arbiter.
- Supports whole-cache invalidate (fence.i) and exports hit/miss counters for performance runs.

---
 rtl/ysyx_icache_pkg.sv | 21 ++
 rtl/ysyx_icache_array.sv | 58 +++++
 rtl/ysyx_icache.sv | 169 ++++++++++++++++
 tb/tb_ysyx_icache.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// derived field widths and the refill FSM state encoding.
package ysyx_icache_pkg;

    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_DATA_W     = 32;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_SETS       = 16;

    localparam int ICACHE_WORD_W  = $clog2(ICACHE_LINE_WORDS);
    localparam int ICACHE_INDEX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W   = ICACHE_ADDR_W - 2 - ICACHE_WORD_W - ICACHE_INDEX_W;

    typedef enum logic [1:0] {
        ysyx_ICACHE_IDLE   = 2'd0,
        ysyx_ICACHE_REFILL = 2'd1,
        ysyx_ICACHE_GAP    = 2'd2,
        ysyx_ICACHE_RESP   = 2'd3
    } icache_state_e;

endpackage

// File: rtl/ysyx_icache_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read port,
// a word write port for refills, a tag write port and a clear-all for fence.i.
module ysyx_icache_array #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(SETS)-1:0]       rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
    output logic                          rd_valid,
    output logic [TAG_W-1:0]              rd_tag,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          wr_en,
    input  logic [$clog2(SETS)-1:0]       wr_index,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          tag_we,
    input  logic [$clog2(SETS)-1:0]       tag_index,
    input  logic [TAG_W-1:0]              tag_data,
    input  logic                          tag_valid,
    input  logic                          clr_all
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS*LINE_WORDS];

    // Clear-all wins over a simultaneous tag write so a flushed refill never stays valid.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[tag_index] <= tag_valid;
        end
    end

    // NOTE: tag/data storage is not reset; nothing reads it until the valid bit is set,
    // and leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[tag_index] <= tag_data;
        end
        if (wr_en) begin
            data_q[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_word}];

endmodule

// File: rtl/ysyx_icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, line refill through
// single-word arbiter reads separated by an arvalid-low cycle, fence.i flush, hit/miss counters.
module ysyx_icache
    import ysyx_icache_pkg::*;
#(
    parameter int ADDR_W     = ICACHE_ADDR_W,
    parameter int DATA_W     = ICACHE_DATA_W,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int SETS       = ICACHE_SETS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_pc,
    input  logic              ifu_req,
    output logic              ifu_ready_o,
    output logic [DATA_W-1:0] ifu_inst_o,
    output logic              ifu_valid_o,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] bus_araddr_o,
    output logic              bus_arvalid_o,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - 2 - WORD_W - INDEX_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    icache_state_e     state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [WORD_W-1:0] beat_q;
    logic              flush_pend_q;

    logic [INDEX_W-1:0] req_index, lat_index, rd_index;
    logic [WORD_W-1:0]  req_word, lat_word, rd_word;
    logic [TAG_W-1:0]   req_tag, lat_tag, rd_tag;
    logic               rd_valid;
    logic [DATA_W-1:0]  rd_data;
    logic               accept, hit, flush_now;
    logic               wr_en, tag_we, tag_valid, clr_all;
    logic               unused_pc_bits;

    assign req_word  = ifu_pc[2 +: WORD_W];
    assign req_index = ifu_pc[2+WORD_W +: INDEX_W];
    assign req_tag   = ifu_pc[ADDR_W-1 -: TAG_W];
    assign lat_word  = pc_q[2 +: WORD_W];
    assign lat_index = pc_q[2+WORD_W +: INDEX_W];
    assign lat_tag   = pc_q[ADDR_W-1 -: TAG_W];
    assign unused_pc_bits = ^{ifu_pc[1:0], pc_q[1:0]};

    // The read port looks up the incoming pc while idle and the latched pc otherwise.
    assign rd_index  = (state_q == ysyx_ICACHE_IDLE) ? req_index : lat_index;
    assign rd_word   = (state_q == ysyx_ICACHE_IDLE) ? req_word  : lat_word;
    assign accept    = ifu_req & ifu_ready_o;
    assign hit       = accept & rd_valid & (rd_tag == req_tag);
    assign flush_now = flush_pend_q | flush_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ysyx_ICACHE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ysyx_ICACHE_IDLE:   if (accept && !hit) state_d = ysyx_ICACHE_REFILL;
            ysyx_ICACHE_REFILL: if (bus_rvalid) state_d = (beat_q == LAST_BEAT) ? ysyx_ICACHE_RESP
                                                                                 : ysyx_ICACHE_GAP;
            ysyx_ICACHE_GAP:    state_d = ysyx_ICACHE_REFILL;
            ysyx_ICACHE_RESP:   state_d = ysyx_ICACHE_IDLE;
            default:            state_d = ysyx_ICACHE_IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        ifu_ready_o   = 1'b0;
        bus_arvalid_o = 1'b0;
        bus_araddr_o  = '0;
        wr_en         = 1'b0;
        tag_we        = 1'b0;
        tag_valid     = 1'b0;
        clr_all       = 1'b0;
        unique case (state_q)
            ysyx_ICACHE_IDLE: begin
                ifu_ready_o = !flush_i;
                clr_all     = flush_i;
            end
            ysyx_ICACHE_REFILL: begin
                bus_arvalid_o = 1'b1;
                bus_araddr_o  = {lat_tag, lat_index, beat_q, 2'b00};
                wr_en         = bus_rvalid;
            end
            ysyx_ICACHE_RESP: begin
                tag_we    = 1'b1;
                tag_valid = !flush_now;
                clr_all   = flush_now;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            ifu_valid_o  <= 1'b0;
            ifu_inst_o   <= '0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
        end else begin
            ifu_valid_o <= 1'b0;
            if (accept) begin
                pc_q <= ifu_pc;
                if (hit) begin
                    ifu_valid_o <= 1'b1;
                    ifu_inst_o  <= rd_data;
                    hit_cnt_o   <= hit_cnt_o + 32'd1;
                end else begin
                    beat_q     <= '0;
                    miss_cnt_o <= miss_cnt_o + 32'd1;
                end
            end
            if (state_q == ysyx_ICACHE_REFILL && bus_rvalid) begin
                beat_q <= beat_q + 1'b1;
            end
            // Every refilled word is already in the array by RESP, so the read port forwards it.
            if (state_q == ysyx_ICACHE_RESP) begin
                ifu_valid_o  <= 1'b1;
                ifu_inst_o   <= rd_data;
                flush_pend_q <= 1'b0;
            end else if (state_q != ysyx_ICACHE_IDLE && flush_i) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    ysyx_icache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (rd_index),
        .rd_word   (rd_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_index  (lat_index),
        .wr_word   (beat_q),
        .wr_data   (bus_rdata),
        .tag_we    (tag_we),
        .tag_index (lat_index),
        .tag_data  (lat_tag),
        .tag_valid (tag_valid),
        .clr_all   (clr_all)
    );

endmodule

// File: tb/tb_ysyx_icache.sv
// Randomized self-checking bench for ysyx_icache: a behavioural cache/memory model,
// a stalling bus responder and a response monitor checked on every output pulse.
module tb_ysyx_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_pc;
    logic        ifu_req;
    logic        ifu_ready_o;
    logic [31:0] ifu_inst_o;
    logic        ifu_valid_o;
    logic        flush_i;
    logic [31:0] bus_araddr_o;
    logic        bus_arvalid_o;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int          n_checks = 0;
    int          n_err    = 0;
    int          max_stall = 0;
    int          stall_sum = 0;
    int          m_hits   = 0;
    int          m_misses = 0;
    logic [31:0] exp_q  [$];
    logic [31:0] ar_log [$];
    bit          mvalid [16];
    logic [23:0] mtag   [16];

    ysyx_icache dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_pc        (ifu_pc),
        .ifu_req       (ifu_req),
        .ifu_ready_o   (ifu_ready_o),
        .ifu_inst_o    (ifu_inst_o),
        .ifu_valid_o   (ifu_valid_o),
        .flush_i       (flush_i),
        .bus_araddr_o  (bus_araddr_o),
        .bus_arvalid_o (bus_arvalid_o),
        .bus_rdata     (bus_rdata),
        .bus_rvalid    (bus_rvalid),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, a[31:16]} + 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    endtask

    // Bus memory: answers each AR after a random stall, checks the AR stays put meanwhile,
    // and occasionally pulses a stray rvalid when no read is outstanding.
    initial begin
        bit          tracking;
        int          left;
        logic [31:0] addr;
        tracking   = 1'b0;
        left       = 0;
        addr       = '0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        forever begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (!rst) begin
                tracking = 1'b0;
            end else if (bus_arvalid_o) begin
                if (!tracking) begin
                    tracking  = 1'b1;
                    addr      = bus_araddr_o;
                    left      = $urandom_range(max_stall, 0);
                    stall_sum += left;
                end else begin
                    check("araddr_stable", bus_araddr_o, addr);
                end
                if (left == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = mem_word(addr);
                    ar_log.push_back(addr);
                    tracking   = 1'b0;
                end else begin
                    left--;
                end
            end else begin
                if (tracking) check("arvalid_held", {31'b0, bus_arvalid_o}, 32'd1);
                tracking = 1'b0;
                if ($urandom_range(7, 0) == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = $urandom;
                end
            end
        end
    end

    // Every ifu_valid_o pulse must match the oldest outstanding expectation.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && ifu_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {31'b0, ifu_valid_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("inst", ifu_inst_o, e);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input bit flush_mid, output int lat, output bit was_hit);
        int          guard;
        int          cycles;
        bit          hit;
        bit          flushed;
        logic [3:0]  idx;
        logic [23:0] tg;
        logic [31:0] base;
        guard = 0;
        while (!ifu_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {31'b0, ifu_ready_o}, 32'd1);
        idx  = pc[7:4];
        tg   = pc[31:8];
        base = {pc[31:4], 4'h0};
        hit  = mvalid[idx] && (mtag[idx] == tg);
        exp_q.push_back(mem_word(pc));
        ar_log.delete();
        stall_sum = 0;
        flushed   = 1'b0;
        ifu_pc    = pc;
        ifu_req   = 1'b1;
        @(negedge clk);
        ifu_req = 1'b0;
        cycles  = 1;
        if (hit) m_hits++; else m_misses++;
        while (!ifu_valid_o && cycles < 400) begin
            if (flush_mid && !flushed && bus_arvalid_o && bus_araddr_o == base + 32'd8) begin
                flush_i = 1'b1;
                flushed = 1'b1;
            end else begin
                flush_i = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        flush_i = 1'b0;
        check("resp_seen", {31'b0, ifu_valid_o}, 32'd1);
        check("latency", cycles, hit ? 32'd1 : 32'(9 + stall_sum));
        check("hit_cnt", hit_cnt_o, m_hits);
        check("miss_cnt", miss_cnt_o, m_misses);
        if (hit) begin
            check("hit_no_bus", ar_log.size(), 32'd0);
        end else begin
            check("beat_count", ar_log.size(), 32'd4);
            for (int k = 0; k < ar_log.size(); k++) check("araddr", ar_log[k], base + 32'(4 * k));
            mvalid[idx] = !flushed;
            mtag[idx]   = tg;
            if (flushed) model_clear();
        end
        lat     = cycles;
        was_hit = hit;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        bit          was_hit;
        int          guard;
        logic [31:0] pc;
        rst     = 1'b0;
        ifu_pc  = '0;
        ifu_req = 1'b0;
        flush_i = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, ifu_ready_o}, 32'd1);
        check("rst_arvalid", {31'b0, bus_arvalid_o}, 32'd0);
        check("rst_araddr", bus_araddr_o, 32'd0);
        check("rst_valid", {31'b0, ifu_valid_o}, 32'd0);
        check("rst_inst", ifu_inst_o, 32'd0);
        check("rst_hits", hit_cnt_o, 32'd0);
        check("rst_misses", miss_cnt_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Cold miss with one-cycle bus latency, then a hit in the same line.
        max_stall = 0;
        fetch(32'h3000_0008, 1'b0, lat, was_hit);
        check("pin_cold_miss", {31'b0, was_hit}, 32'd0);
        check("pin_cold_latency", lat, 32'd9);
        check("pin_cold_beat2", ar_log[2], 32'h3000_0008);
        check("pin_cold_misses", miss_cnt_o, 32'd1);
        fetch(32'h3000_000C, 1'b0, lat, was_hit);
        check("pin_hit_latency", lat, 32'd1);
        check("pin_hit_count", hit_cnt_o, 32'd1);

        // Same index, different tag evicts the line.
        fetch(32'h3000_0108, 1'b0, lat, was_hit);
        fetch(32'h3000_0008, 1'b0, lat, was_hit);
        check("pin_conflict_miss", {31'b0, was_hit}, 32'd0);
        check("pin_conflict_misses", miss_cnt_o, 32'd3);

        // Random fetches over a small conflicting footprint with bus stalls.
        max_stall = 5;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(2, 0))
                0:       pc = 32'h3000_0000;
                1:       pc = 32'h3000_0100;
                default: pc = 32'h8000_1000;
            endcase
            pc[5:4] = 2'($urandom_range(3, 0));
            pc[3:2] = 2'($urandom_range(3, 0));
            fetch(pc, 1'b0, lat, was_hit);
        end

        // fence.i during the beat-2 wait: the fetch still completes, the line is not kept.
        fetch(32'h4000_0024, 1'b1, lat, was_hit);
        fetch(32'h4000_0024, 1'b0, lat, was_hit);
        check("pin_flush_mid_miss", {31'b0, was_hit}, 32'd0);

        // fence.i in IDLE alongside a request: request ignored, lines invalidated.
        fetch(32'h3000_0024, 1'b0, lat, was_hit);
        fetch(32'h3000_0024, 1'b0, lat, was_hit);
        check("pin_refetch_hit", {31'b0, was_hit}, 32'd1);
        flush_i = 1'b1;
        ifu_req = 1'b1;
        ifu_pc  = 32'h3000_0024;
        #1;
        check("flush_idle_ready", {31'b0, ifu_ready_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        ifu_req = 1'b0;
        model_clear();
        fetch(32'h3000_0024, 1'b0, lat, was_hit);
        check("pin_flush_idle_miss", {31'b0, was_hit}, 32'd0);

        // Reset while waiting on beat 1 of a refill.
        max_stall = 3;
        pc = 32'h3000_0018;
        guard = 0;
        while (!ifu_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ifu_pc  = pc;
        ifu_req = 1'b1;
        @(negedge clk);
        ifu_req = 1'b0;
        guard   = 0;
        while (!(bus_arvalid_o && bus_araddr_o == 32'h3000_0014) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reach_beat1", bus_araddr_o, 32'h3000_0014);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_arvalid", {31'b0, bus_arvalid_o}, 32'd0);
        check("midrst_ready", {31'b0, ifu_ready_o}, 32'd1);
        check("midrst_hits", hit_cnt_o, 32'd0);
        check("midrst_misses", miss_cnt_o, 32'd0);
        @(negedge clk);
        rst      = 1'b1;
        m_hits   = 0;
        m_misses = 0;
        model_clear();
        fetch(pc, 1'b0, lat, was_hit);
        check("pin_post_rst_miss", {31'b0, was_hit}, 32'd0);
        check("pin_post_rst_misses", miss_cnt_o, 32'd1);

        repeat (4) @(negedge clk);
        check("no_pending_resp", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
